// File: rtl/control_contador_pkg.sv
// Shared types and constants for the contador controller.
// Holds the FSM state encoding, the MODO codes and a next-state helper.
package control_contador_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    localparam logic [1:0] ASC   = 2'b00;
    localparam logic [1:0] DESC  = 2'b01;
    localparam logic [1:0] TRES  = 2'b10;
    localparam logic [1:0] CARGA = 2'b11;

    // State entered right after a command is accepted.
    function automatic state_t accept_next(
        input logic [1:0] modo,
        input logic       len_zero
    );
        if (modo == CARGA) begin
            return S_LOAD;
        end else if (len_zero) begin
            return S_FIN;
        end else begin
            return S_RUN;
        end
    endfunction

endpackage

// File: rtl/control_contador_sat.sv
// Saturating event counter with synchronous clear and increment enable.
// Ports: clk/rst_n, clr_i (clear, wins over inc), inc_i, cnt_o.
module contador_sat #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/control_contador.sv
// Command-driven controller for a 4-bit up/down/load contador.
// Ports: CLK, RESET_L, CMD_* handshake, ABORT, RCO in; MODO, D, ENB, BUSY, DONE, RCO_CNT out.
module control_contador
    import control_contador_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int RCNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_MODO,
    input  logic [3:0]        CMD_DATO,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic              ABORT,
    input  logic              RCO,
    output logic [1:0]        MODO,
    output logic [3:0]        D,
    output logic              ENB,
    output logic              BUSY,
    output logic              DONE,
    output logic [RCNT_W-1:0] RCO_CNT
);

    state_t            state_q, state_d;
    logic [1:0]        modo_q, modo_d;
    logic [3:0]        dato_q, dato_d;
    logic [LEN_W-1:0]  len_q, len_d;
    // Last values presented to the contador, held while idle.
    logic [1:0]        modo_hold_q, modo_hold_d;
    logic [3:0]        d_hold_q, d_hold_d;
    logic              accept;

    assign accept = CMD_VALID && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        modo_d      = modo_q;
        dato_d      = dato_q;
        len_d       = len_q;
        modo_hold_d = modo_hold_q;
        d_hold_d    = d_hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    modo_d  = CMD_MODO;
                    dato_d  = CMD_DATO;
                    len_d   = CMD_LEN;
                    state_d = accept_next(CMD_MODO, CMD_LEN == '0);
                end
            end
            S_LOAD: begin
                modo_hold_d = CARGA;
                d_hold_d    = dato_q;
                state_d     = S_FIN;
            end
            S_RUN: begin
                modo_hold_d = modo_q;
                // Exit on the last cycle so the count never wraps below 1.
                if (ABORT || (len_q <= LEN_W'(1))) begin
                    state_d = S_FIN;
                end else begin
                    len_d = len_q - LEN_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= S_IDLE;
            modo_q      <= ASC;
            dato_q      <= '0;
            len_q       <= '0;
            modo_hold_q <= ASC;
            d_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            modo_q      <= modo_d;
            dato_q      <= dato_d;
            len_q       <= len_d;
            modo_hold_q <= modo_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

    always_comb begin
        CMD_READY = 1'b0;
        ENB       = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        MODO      = modo_hold_q;
        D         = d_hold_q;
        unique case (state_q)
            S_IDLE: begin
                CMD_READY = 1'b1;
                BUSY      = 1'b0;
            end
            S_LOAD: begin
                ENB  = 1'b1;
                MODO = CARGA;
                D    = dato_q;
            end
            S_RUN: begin
                ENB  = 1'b1;
                MODO = modo_q;
            end
            S_FIN: begin
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    contador_sat #(
        .W(RCNT_W)
    ) u_rco_cnt (
        .clk   (CLK),
        .rst_n (RESET_L),
        .clr_i (accept),
        .inc_i ((state_q == S_RUN) && RCO),
        .cnt_o (RCO_CNT)
    );

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador driving a behavioural contador.
// Per-cycle expectations are queued at command issue and popped each cycle.
module tb_control_contador;

    localparam int LEN_W  = 8;
    localparam int RCNT_W = 2;
    localparam int SATV   = (1 << RCNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RESET_L = 1'b0;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic [1:0]        CMD_MODO = 2'b00;
    logic [3:0]        CMD_DATO = 4'h0;
    logic [LEN_W-1:0]  CMD_LEN = '0;
    logic              ABORT = 1'b0;
    logic              RCO;
    logic [1:0]        MODO;
    logic [3:0]        D;
    logic              ENB;
    logic              BUSY;
    logic              DONE;
    logic [RCNT_W-1:0] RCO_CNT;

    control_contador #(
        .LEN_W  (LEN_W),
        .RCNT_W (RCNT_W)
    ) dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_MODO  (CMD_MODO),
        .CMD_DATO  (CMD_DATO),
        .CMD_LEN   (CMD_LEN),
        .ABORT     (ABORT),
        .RCO       (RCO),
        .MODO      (MODO),
        .D         (D),
        .ENB       (ENB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RCO_CNT   (RCO_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic rco_of(input logic [3:0] q, input logic [1:0] m);
        return (m == 2'b00 && q == 4'hF) ||
               (m == 2'b01 && q == 4'h0) ||
               (m == 2'b10 && q < 4'h3);
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] q, input logic [1:0] m,
                                       input logic [3:0] d);
        case (m)
            2'b00:   return q + 4'd1;
            2'b01:   return q - 4'd1;
            2'b10:   return q - 4'd3;
            default: return d;
        endcase
    endfunction

    // Behavioural downstream contador.
    logic [3:0] q_cnt;
    always @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) q_cnt <= 4'h0;
        else if (ENB) q_cnt <= nxt(q_cnt, MODO, D);
    end
    assign RCO = rco_of(q_cnt, MODO);

    typedef struct packed {
        logic       enb;
        logic [1:0] modo;
        logic [3:0] d;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    logic [1:0] cur_modo = 2'b00;
    logic [3:0] cur_d = 4'h0;
    int         exp_rco = 0;

    function automatic exp_t obs();
        return {ENB, MODO, D, BUSY, DONE, CMD_READY};
    endfunction

    task automatic push_cmd(input logic [1:0] m, input logic [3:0] dt,
                            input int len, input int abort_k,
                            input logic [3:0] q0);
        int n;
        int ev;
        logic [3:0] q;
        n = 0;
        if (m == 2'b11) begin
            cur_modo = m;
            cur_d = dt;
            sbq.push_back(exp_t'({1'b1, m, dt, 1'b1, 1'b0, 1'b0}));
        end else begin
            n = (abort_k > 0 && abort_k < len) ? abort_k : len;
            if (n > 0) cur_modo = m;
            for (int i = 0; i < n; i++)
                sbq.push_back(exp_t'({1'b1, m, cur_d, 1'b1, 1'b0, 1'b0}));
        end
        sbq.push_back(exp_t'({1'b0, cur_modo, cur_d, 1'b1, 1'b1, 1'b0}));
        sbq.push_back(exp_t'({1'b0, cur_modo, cur_d, 1'b0, 1'b0, 1'b1}));
        ev = 0;
        q = q0;
        for (int i = 0; i < n; i++) begin
            if (rco_of(q, m)) ev++;
            q = nxt(q, m, dt);
        end
        exp_rco = (ev > SATV) ? SATV : ev;
    endtask

    task automatic issue(input logic [1:0] m, input logic [3:0] dt,
                         input int len, input int abort_k,
                         input logic abort_acc, input logic hold);
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_MODO = m;
        CMD_DATO = dt;
        CMD_LEN = LEN_W'(len);
        ABORT = abort_acc;
        push_cmd(m, dt, len, abort_k, q_cnt);
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        if (!hold) CMD_VALID = 1'b0;
    endtask

    // Pops one expectation per cycle; ABORT raised after the abort_k-th entry.
    task automatic drain(input string tag, input int abort_k);
        exp_t e;
        exp_t o;
        int i;
        logic prev_idle;
        i = 0;
        prev_idle = 1'b0;
        while (sbq.size() > 0) begin
            @(negedge CLK);
            ABORT = 1'b0;
            if (prev_idle) CMD_VALID = 1'b0;
            e = sbq.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s cyc%0d got=%b need=%b", tag, i + 1, o, e);
            end
            if (abort_k > 0 && i == abort_k - 1) ABORT = 1'b1;
            prev_idle = e.rdy;
            i++;
        end
        CMD_VALID = 1'b0;
    endtask

    task automatic check_rco(input string tag);
        checks++;
        if (int'(RCO_CNT) !== exp_rco) begin
            failures++;
            $display("FAIL %s rco_cnt got=%0d need=%0d", tag, RCO_CNT, exp_rco);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET_L = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        cur_modo = 2'b00;
        cur_d = 4'h0;
    endtask

    task automatic test_reset();
        exp_t e;
        RESET_L = 1'b0;
        repeat (2) @(negedge CLK);
        e = exp_t'({1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1});
        checks++;
        if (obs() !== e || RCO_CNT !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b/%0d need=%b/0", obs(), RCO_CNT, e);
        end
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b need=1", CMD_READY);
        end
    endtask

    task automatic test_run_up();
        issue(2'b00, 4'h0, 5, 0, 1'b0, 1'b0);
        drain("run_up5", 0);
        check_rco("run_up5");
    endtask

    task automatic test_load();
        issue(2'b11, 4'b1010, 3, 0, 1'b0, 1'b0);
        drain("load", 0);
        checks++;
        if (q_cnt !== 4'b1010) begin
            failures++;
            $display("FAIL load_q got=%b need=1010", q_cnt);
        end
    endtask

    task automatic test_rco_count();
        pulse_reset();
        issue(2'b00, 4'h0, 40, 0, 1'b0, 1'b0);
        drain("rco40", 0);
        checks++;
        if (RCO_CNT !== RCNT_W'(2)) begin
            failures++;
            $display("FAIL rco40 rco_cnt got=%0d need=2", RCO_CNT);
        end
    endtask

    task automatic test_abort();
        int frozen;
        issue(2'b00, 4'h0, 10, 3, 1'b0, 1'b0);
        drain("abort3", 3);
        check_rco("abort3");
        frozen = exp_rco;
        repeat (3) @(negedge CLK);
        checks++;
        if (int'(RCO_CNT) !== frozen) begin
            failures++;
            $display("FAIL abort_frozen got=%0d need=%0d", RCO_CNT, frozen);
        end
    endtask

    task automatic test_len_zero();
        issue(2'b01, 4'h5, 0, 0, 1'b0, 1'b0);
        drain("len0", 0);
        check_rco("len0");
    endtask

    task automatic test_abort_idle();
        issue(2'b10, 4'h0, 3, 0, 1'b1, 1'b0);
        drain("abort_idle", 0);
    endtask

    task automatic test_back_to_back();
        issue(2'b00, 4'h0, 4, 0, 1'b0, 1'b1);
        CMD_MODO = 2'b11;
        CMD_DATO = 4'h6;
        CMD_LEN = LEN_W'(7);
        push_cmd(2'b11, 4'h6, 7, 0, 4'h0);
        drain("b2b", 0);
    endtask

    task automatic test_saturation();
        pulse_reset();
        issue(2'b00, 4'h0, (1 << LEN_W) - 1, 0, 1'b0, 1'b0);
        drain("maxlen", 0);
        checks++;
        if (RCO_CNT !== RCNT_W'(SATV)) begin
            failures++;
            $display("FAIL sat got=%0d need=%0d", RCO_CNT, SATV);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        issue(2'b01, 4'h0, 10, 0, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        #2;
        RESET_L = 1'b0;
        #1;
        checks++;
        if (ENB !== 1'b0 || MODO !== 2'b00 || BUSY !== 1'b0 ||
            DONE !== 1'b0 || RCO_CNT !== '0) begin
            failures++;
            $display("FAIL rst_run got=%b%b%b%b/%0d need=00000/0",
                     ENB, MODO, BUSY, DONE, RCO_CNT);
        end
        sbq.delete();
        cur_modo = 2'b00;
        cur_d = 4'h0;
        @(negedge CLK);
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL rst_run_ready got=%b need=1", CMD_READY);
        end
        seen_done = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL rst_run_done got=%0d need=0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_load();
        test_rco_count();
        test_abort();
        test_len_zero();
        test_abort_idle();
        test_back_to_back();
        test_saturation();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_contador.md
CONTROL_CONTADOR -- requirements
Module: control_contador

Interface
REQ-001 The block SHALL take parameter LEN_W, default 8, as the width of the run-length field and of the internal remaining-cycle counter.
REQ-002 The block SHALL take parameter RCNT_W, default 8, as the width of the RCO event counter.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 The block SHALL provide these ports (name, direction, width, meaning):
- CLK  in  1  single rising-edge clock, shared with the downstream contador.
- RESET_L  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  block can accept a command this cycle.
- CMD_MODO  in  2  requested counter mode: 00 up, 01 down, 10 down-by-3, 11 parallel load.
- CMD_DATO  in  4  parallel-load value.
- CMD_LEN  in  LEN_W  number of enabled counting cycles.
- ABORT  in  1  terminate the current operation.
- RCO  in  1  ripple-carry output returned from the contador.
- MODO  out  2  mode to the contador.
- D  out  4  load data to the contador.
- ENB  out  1  enable to the contador.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle completion pulse.
- RCO_CNT  out  RCNT_W  RCO events seen in the last or current run.

Function
REQ-005 The block SHALL implement a Moore FSM with states IDLE, LOAD, RUN and FIN; MODO, D, ENB, BUSY, DONE and CMD_READY SHALL decode from registered state only.
REQ-006 In IDLE: CMD_READY=1, ENB=0, BUSY=0, DONE=0.
REQ-007 A command SHALL be accepted on the edge where CMD_VALID=1 and CMD_READY=1, latching CMD_MODO, CMD_DATO and CMD_LEN and clearing RCO_CNT to 0.
REQ-008 After acceptance, the next state SHALL be:
- LOAD if CMD_MODO=11;
- otherwise FIN if CMD_LEN=0;
- otherwise RUN.
REQ-009 LOAD SHALL last exactly one cycle with ENB=1, MODO=11, D=latched dato, BUSY=1, then go to FIN.
REQ-010 RUN SHALL hold ENB=1, MODO=latched mode and BUSY=1 for exactly CMD_LEN consecutive cycles, decrementing the remaining count each cycle, then go to FIN.
REQ-011 FIN SHALL last exactly one cycle with DONE=1, ENB=0, BUSY=1, CMD_READY=0, then return to IDLE.
REQ-012 When idle (ENB=0), MODO and D SHALL hold their last driven values.
REQ-013 CMD_READY SHALL be 0 in LOAD, RUN and FIN; CMD_VALID in those states SHALL be ignored and the command SHALL not be lost to the requester (handshake not completed).
REQ-014 RCO_CNT SHALL increment on every cycle in which the state is RUN and RCO=1.
REQ-015 RCO_CNT SHALL saturate at 2^RCNT_W-1 and SHALL hold its value from FIN until the next acceptance.
REQ-016 ABORT=1 sampled in LOAD or RUN SHALL force the next state to FIN; ENB in the sampling cycle remains 1, and DONE still pulses.
REQ-017 ABORT in IDLE or FIN SHALL have no effect; when ABORT and an acceptance coincide in IDLE, the acceptance SHALL win.
REQ-018 Maximum run SHALL be CMD_LEN=2^LEN_W-1; the remaining counter SHALL not wrap.

Reset
REQ-019 RESET_L=0 SHALL asynchronously force state IDLE, MODO=00, D=0000, ENB=0, BUSY=0, DONE=0, RCO_CNT=0 and latched fields 0.
REQ-020 Reset asserted mid-LOAD or mid-RUN SHALL drop ENB immediately, with no DONE pulse.
REQ-021 After release, CMD_READY SHALL be 1 on the first clock.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding and the MODO constants (ASC=00, DESC=01, TRES=10, CARGA=11).
REQ-023 The RCO event counter SHALL be one sub-module, contador_sat (width-parameterised saturating counter with synchronous clear and increment enable).
REQ-024 The remaining-cycle counter SHALL stay inline.

Verification
REQ-025 Accept MODO=00, LEN=5 -> ENB=1 for exactly 5 cycles, MODO=00, DONE pulse on the 6th cycle after acceptance, CMD_READY=1 on the 7th.
REQ-026 Accept MODO=11, DATO=1010 -> one cycle ENB=1, MODO=11, D=1010, then DONE; the contador Q reads 1010.
REQ-027 Accept MODO=00, LEN=40, with contador starting at Q=0 -> RCO_CNT=2 after DONE (wraps at 15 and 31).
REQ-028 Assert ABORT in the 3rd RUN cycle of LEN=10 -> ENB high for 3 cycles total, DONE next cycle, RCO_CNT frozen.
REQ-029 Accept LEN=0 with MODO=01 -> ENB never asserted, DONE one cycle after acceptance.
REQ-030 Pulse RESET_L low during RUN -> ENB=0, MODO=00 immediately; no DONE; CMD_READY=1 after release.
